async_bus_master_fsm: RTL and testbench
=======================================

# async_bus_master_fsm

Parametrised asynchronous bus-master cycle sequencer for the SCSI DMA controller's host-side bus interface. It generalises the read-only cycle FSM to read and write cycles, configurable address and data widths, and 68030-style SIZ outputs. It adds synchronised DSACK/BERR handshakes, dynamic port-size reporting and an optional bus timeout. It sits between the DMA/register engine (simple request/acknowledge interface) and the external 68030-style bus pins.

## Interface
Parameters:
- ADDR_W, 32, address bus width
- DATA_W, 32, data bus width
- TIMEOUT, 64, maximum WAIT cycles before forced termination (used only with BUS_TIMEOUT_EN); must be ≥1

Ports:
- Clk  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ  in  1  start-cycle request; sampled only in IDLE
- REQ_RW  in  1  1 = read, 0 = write
- REQ_ADDR  in  ADDR_W  cycle address
- REQ_WDATA  in  DATA_W  write data
- REQ_SIZ  in  2  transfer size (00 = long, 01 = byte, 10 = word, 11 = 3-byte)
- BUSY  out  1  high in every state except IDLE
- ACK  out  1  one-cycle completion pulse
- ERR  out  1  valid with ACK; cycle ended by BERR or timeout
- TOUT  out  1  valid with ACK; cycle ended by timeout
- RDATA  out  DATA_W  read data, updated only on a successful read
- ACK_SIZE  out  2  inverted DSACK captured at termination (port size)
- ADDR  out  ADDR_W  bus address
- SIZ  out  2  bus size
- RW  out  1  bus direction, 1 = read
- _AS, _DS  out  1  address/data strobes, active-low
- DATA_OUT  out  DATA_W  write data to pads
- DATA_OE  out  1  pad output enable
- DATA_IN  in  DATA_W  read data from pads
- _DSACK  in  2  data-size acknowledge, active-low, asynchronous
- _BERR  in  1  bus error, active-low, asynchronous

## Operation
- _DSACK and _BERR pass through a 2-flop synchroniser. The synchroniser flops reset to 1. "Asserted" means the second flop is low.
- States: IDLE, S0, S1, S2, WAIT, LATCH, END, RECOVER.
- IDLE: when REQ=1, capture all REQ_* fields and go to S0. REQ is ignored when not in IDLE; it is not queued.
- S0: drive ADDR, SIZ and RW. For a write, also drive DATA_OUT and set DATA_OE=1. Go to S1.
- S1: _AS=0. For a read, _DS=0 and go to WAIT. For a write, go to S2.
- S2 (write only): _DS=0. Go to WAIT.
- WAIT: strobes are held.
  - If BERR is asserted: go to END with ERR=1.
  - Else if either DSACK bit is asserted: go to LATCH.
  - Else, with BUS_TIMEOUT_EN, increment the wait counter. When the counter equals TIMEOUT, go to END with ERR=1 and TOUT=1.
- LATCH: capture ACK_SIZE = ~sync_DSACK. For a read, RDATA ← DATA_IN. Go to END.
- END: _AS=1, _DS=1, DATA_OE=0, ACK=1. ERR and TOUT are driven from the latched termination cause. ADDR, SIZ and RW are held. Go to RECOVER.
- RECOVER: wait until sync_DSACK=11 and sync_BERR=1, then go to IDLE. ADDR, SIZ and RW hold until IDLE, then RW=1.
- Simultaneous BERR and DSACK in WAIT: BERR wins. RDATA is unchanged; ACK_SIZE captures the DSACK value.
- ERR and TOUT are cleared on the next accepted request.

## Timing
- Reset values (all outputs):
  - _AS=1, _DS=1, RW=1
  - ADDR=0, SIZ=0
  - DATA_OUT=0, DATA_OE=0
  - ACK=0, ERR=0, TOUT=0
  - RDATA=0, ACK_SIZE=0, BUSY=0
  - State IDLE, wait counter 0.
- Reset mid-cycle: reset values apply at the next edge; the strobes negate immediately.
- Let E0 be the edge that accepts REQ.
  - Read: _AS and _DS fall after E1.
  - Write: _AS falls after E1; _DS falls after E2.
- If DSACK has been asserted at the pins for at least 2 cycles before WAIT is entered, WAIT lasts 1 cycle.
- Best-case completion: ACK is high in the cycle after E5 (read) or E6 (write).
- Otherwise, completion comes 2 cycles after the DSACK pin edge is seen by the first synchroniser flop, plus LATCH and END.
- Timeout: ERR=1 with ACK occurs after exactly TIMEOUT WAIT cycles plus END. The counter clears on entry to WAIT.
- BUSY rises the cycle after E0 and falls on entry to IDLE.
- ACK lasts exactly 1 cycle per accepted request.

## Configuration
- BUS_TIMEOUT_EN defined: the wait counter and TIMEOUT path are present; TOUT can assert.
- BUS_TIMEOUT_EN undefined: WAIT holds indefinitely until DSACK or BERR. TOUT is tied to 0 and the counter is not synthesised.

## Test plan
- Read: REQ_RW=1, REQ_ADDR=0x00DD0040, REQ_SIZ=00, DATA_IN=0xCAFEF00D, _DSACK=00 held low -> ACK after E5, RDATA=0xCAFEF00D, ACK_SIZE=11, ERR=0; _AS and _DS low together for 3 cycles.
- Write: REQ_RW=0, REQ_WDATA=0x12345678, _DSACK=10 asserted 3 cycles after _AS falls -> _DS falls 1 cycle after _AS; DATA_OE=1 from S0 to END; DATA_OUT=0x12345678; ACK_SIZE=01.
- Bus error: _BERR=0 and _DSACK=00 in the same cycle during a read -> ERR=1, TOUT=0, RDATA unchanged; no return to IDLE until _BERR=1 and _DSACK=11.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=8): no DSACK -> ACK with ERR=1 and TOUT=1 exactly 8 WAIT cycles plus END after entering WAIT. Without the macro: BUSY stays high for ≥1000 cycles.
- Reset mid-WAIT: RST=1 for 1 cycle -> the next edge gives _AS=1, _DS=1, BUSY=0, ADDR=0, and no ACK.
- Back-to-back: REQ held high across a completed cycle -> the second request is accepted only on the first IDLE cycle; no request is accepted while BUSY=1.

Source files
------------

// File: rtl/async_bus_master_fsm.sv
// Asynchronous 68030-style bus-master cycle sequencer: turns one request from the
// DMA/register engine into a read or write bus cycle. DSACK/BERR are synchronised,
// the port size is reported back, and read data is latched.
// Optional feature macro: BUS_TIMEOUT_EN adds the WAIT-state timeout counter and TOUT.
module async_bus_master_fsm #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic              REQ,
  input  logic              REQ_RW,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [1:0]        REQ_SIZ,
  output logic              BUSY,
  output logic              ACK,
  output logic              ERR,
  output logic              TOUT,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        ACK_SIZE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [1:0]        SIZ,
  output logic              RW,
  output logic              _AS,
  output logic              _DS,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [1:0]        _DSACK,
  input  logic              _BERR
);

  typedef enum logic [2:0] {
    StIdle, StS0, StS1, StS2, StWait, StLatch, StEnd, StRecover
  } state_e;

  state_e            state_q;
  logic [1:0]        dsack_s1, dsack_s2;
  logic              berr_s1, berr_s2;
  logic              as_n_q, ds_n_q, rw_q, data_oe_q;
  logic              busy_q, ack_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        siz_q, ack_size_q;
  logic [DATA_W-1:0] data_out_q, rdata_q;
  logic              dsack_hit, berr_hit, bus_idle, timeout_hit, enter_end;

  assign dsack_hit = (dsack_s2 != 2'b11);
  assign berr_hit  = ~berr_s2;
  assign bus_idle  = (dsack_s2 == 2'b11) && berr_s2;

  // Two-flop synchronisers for the asynchronous slave handshakes; idle level is 1.
  always_ff @(posedge Clk) begin
    if (RST) begin
      dsack_s1 <= 2'b11;
      dsack_s2 <= 2'b11;
      berr_s1  <= 1'b1;
      berr_s2  <= 1'b1;
    end else begin
      dsack_s1 <= _DSACK;
      dsack_s2 <= dsack_s1;
      berr_s1  <= _BERR;
      berr_s2  <= berr_s1;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] wait_cnt_q;
  logic [CntW-1:0] wait_cnt_inc;
  logic            tout_q;

  assign wait_cnt_inc = wait_cnt_q + CntW'(1);
  assign timeout_hit  = (wait_cnt_inc == CntW'(TIMEOUT));
  assign TOUT         = tout_q;

  // WAIT-cycle counter; held at zero outside WAIT so every WAIT entry starts fresh.
  always_ff @(posedge Clk) begin
    if (RST || state_q != StWait) wait_cnt_q <= '0;
    else                          wait_cnt_q <= wait_cnt_inc;
  end

  // Timeout cause flag, cleared by the next accepted request.
  always_ff @(posedge Clk) begin
    if (RST) begin
      tout_q <= 1'b0;
    end else if (state_q == StIdle && REQ) begin
      tout_q <= 1'b0;
    end else if (state_q == StWait && !berr_hit && !dsack_hit && timeout_hit) begin
      tout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign TOUT        = 1'b0;
`endif

  // Cycles that leave the strobed part of the bus cycle and enter END.
  always_comb begin
    enter_end = (state_q == StLatch) || (state_q == StWait && (berr_hit || timeout_hit));
  end

  // Cycle sequencer; every output is registered on the transition into its state.
  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q    <= StIdle;
      as_n_q     <= 1'b1;
      ds_n_q     <= 1'b1;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      siz_q      <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ack_size_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ) begin
            state_q <= StS0;
            busy_q  <= 1'b1;
            addr_q  <= REQ_ADDR;
            siz_q   <= REQ_SIZ;
            rw_q    <= REQ_RW;
            err_q   <= 1'b0;
            if (!REQ_RW) begin
              data_out_q <= REQ_WDATA;
              data_oe_q  <= 1'b1;
            end
          end
        end
        StS0: begin
          // Reads strobe _DS together with _AS; writes wait one cycle for data setup.
          as_n_q  <= 1'b0;
          ds_n_q  <= ~rw_q;
          state_q <= StS1;
        end
        StS1: begin
          state_q <= rw_q ? StWait : StS2;
          if (!rw_q) ds_n_q <= 1'b0;
        end
        StS2: begin
          state_q <= StWait;
        end
        StWait: begin
          if (berr_hit) begin
            // BERR wins over a simultaneous DSACK; port size is still reported.
            state_q    <= StEnd;
            err_q      <= 1'b1;
            ack_size_q <= ~dsack_s2;
          end else if (dsack_hit) begin
            state_q <= StLatch;
          end else if (timeout_hit) begin
            state_q    <= StEnd;
            err_q      <= 1'b1;
            ack_size_q <= ~dsack_s2;
          end
        end
        StLatch: begin
          ack_size_q <= ~dsack_s2;
          if (rw_q) rdata_q <= DATA_IN;
          state_q <= StEnd;
        end
        StEnd: begin
          ack_q   <= 1'b1;
          state_q <= StRecover;
        end
        StRecover: begin
          // Hold off the next cycle until the slave has released its handshakes.
          if (bus_idle) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            rw_q    <= 1'b1;
          end
        end
      endcase
      if (enter_end) begin
        as_n_q    <= 1'b1;
        ds_n_q    <= 1'b1;
        data_oe_q <= 1'b0;
      end
    end
  end

  timeout_param_a: assert property (@(posedge Clk) TIMEOUT >= 1);

  // Strobes negate as soon as reset is raised rather than waiting for the edge.
  assign _AS      = as_n_q | RST;
  assign _DS      = ds_n_q | RST;
  assign RW       = rw_q;
  assign ADDR     = addr_q;
  assign SIZ      = siz_q;
  assign DATA_OUT = data_out_q;
  assign DATA_OE  = data_oe_q;
  assign BUSY     = busy_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign ACK_SIZE = ack_size_q;

endmodule

// File: tb/tb_async_bus_master_fsm.sv
// Self-checking bench for async_bus_master_fsm: a transaction-timeline model checked
// every cycle, plus directed read/write/BERR/timeout/reset/back-to-back scenarios.
module tb_async_bus_master_fsm;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, req, req_rw;
  logic [31:0] req_addr, req_wdata, din;
  logic [1:0]  req_siz, dsack_n;
  logic        berr_n;
  logic        busy, ack, err, tout, rw, as_n, ds_n, data_oe;
  logic [31:0] rdata, addr, data_out;
  logic [1:0]  ack_size, siz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  bit check_en = 1'b0;

  async_bus_master_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .Clk(clk), .RST(rst), .REQ(req), .REQ_RW(req_rw), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_SIZ(req_siz), .BUSY(busy), .ACK(ack), .ERR(err),
    .TOUT(tout), .RDATA(rdata), .ACK_SIZE(ack_size), .ADDR(addr), .SIZ(siz), .RW(rw),
    ._AS(as_n), ._DS(ds_n), .DATA_OUT(data_out), .DATA_OE(data_oe), .DATA_IN(din),
    ._DSACK(dsack_n), ._BERR(berr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is described by its offset from the accepting edge and the
  // offset at which END is reached; outputs follow from those two numbers.
  bit          m_busy, m_rw, m_err, m_tout;
  int          m_off, m_tend, m_w;
  logic [31:0] m_addr, m_dout, m_rdata;
  logic [1:0]  m_siz, m_acks, h1_dsack, h2_dsack;
  logic        h1_berr, h2_berr;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_rw = 1; m_err = 0; m_tout = 0; m_off = 0; m_tend = -1; m_w = 2;
        m_addr = 0; m_dout = 0; m_rdata = 0; m_siz = 0; m_acks = 0;
        h1_dsack = 2'b11; h2_dsack = 2'b11; h1_berr = 1; h2_berr = 1;
      end else begin
        if (!m_busy) begin
          if (req) begin
            m_busy = 1; m_off = 0; m_tend = -1; m_w = req_rw ? 2 : 3;
            m_rw = req_rw; m_addr = req_addr; m_siz = req_siz;
            if (!req_rw) m_dout = req_wdata;
            m_err = 0; m_tout = 0;
          end
        end else begin
          if (m_tend < 0 && m_off >= m_w) begin
            if (!h2_berr) begin
              m_tend = m_off + 1; m_err = 1; m_acks = ~h2_dsack;
            end else if (h2_dsack != 2'b11) begin
              m_tend = m_off + 2;
`ifdef BUS_TIMEOUT_EN
            end else if (m_off - m_w + 1 == TO) begin
              m_tend = m_off + 1; m_err = 1; m_tout = 1; m_acks = ~h2_dsack;
`endif
            end
          end else if (m_tend >= 0 && m_off == m_tend - 1) begin
            m_acks = ~h2_dsack;
            if (m_rw) m_rdata = din;
          end else if (m_tend >= 0 && m_off >= m_tend + 1 && h2_dsack == 2'b11 && h2_berr) begin
            m_busy = 0; m_rw = 1;
          end
          m_off++;
        end
        h2_dsack = h1_dsack; h1_dsack = dsack_n;
        h2_berr = h1_berr; h1_berr = berr_n;
      end
      #1;
      if (check_en) begin
        bit live, e_as, e_ds, e_oe, e_ack;
        live  = m_busy && (m_tend < 0 || m_off < m_tend);
        e_as  = !(live && m_off >= 1) | rst;
        e_ds  = !(live && m_off >= (m_rw ? 1 : 2)) | rst;
        e_oe  = live && !m_rw;
        e_ack = m_busy && m_tend >= 0 && m_off == m_tend + 1;
        chk("cyc_busy", busy, m_busy);
        chk("cyc_ack", ack, e_ack);
        chk("cyc_as_n", as_n, e_as);
        chk("cyc_ds_n", ds_n, e_ds);
        chk("cyc_data_oe", data_oe, e_oe);
        chk("cyc_rw", rw, m_rw);
        chk("cyc_addr", addr, m_addr);
        chk("cyc_siz", siz, m_siz);
        chk("cyc_data_out", data_out, m_dout);
        chk("cyc_rdata", rdata, m_rdata);
        chk("cyc_ack_size", ack_size, m_acks);
        chk("cyc_err", err, m_err);
        chk("cyc_tout", tout, m_tout);
      end
    end
  end

  function automatic bit cond(input int which);
    case (which)
      0:       return ack;
      1:       return !busy;
      2:       return !as_n;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait at negedges; an expired bound counts as a failed comparison.
  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!cond(which) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cond(which)) begin
      failures++;
      $display("FAIL %s: condition not reached within %0d cycles", name, n);
    end
  endtask

  task automatic issue(input bit rw_i, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] wd);
    req = 1; req_rw = rw_i; req_addr = a; req_siz = s; req_wdata = wd;
    @(negedge clk);
    c0 = cyc;
    req = 0;
  endtask

  initial begin
    int n, both;
    rst = 1; req = 0; req_rw = 1; req_addr = 0; req_wdata = 0; req_siz = 0;
    din = 0; dsack_n = 2'b11; berr_n = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    check_en = 1;
    chk("rst_as_n", as_n, 1); chk("rst_ds_n", ds_n, 1); chk("rst_rw", rw, 1);
    chk("rst_addr", addr, 0); chk("rst_busy", busy, 0); chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0); chk("rst_ack_size", ack_size, 0);
    chk("rst_data_oe", data_oe, 0);
    @(negedge clk);

    // Best-case long read with DSACK already held low.
    din = 32'hCAFEF00D; dsack_n = 2'b00;
    issue(1, 32'h00DD0040, 2'b00, 0);
    n = 0; both = 0;
    while (!ack && n < 50) begin
      if (!as_n && !ds_n) both++;
      @(negedge clk);
      n++;
    end
    chk("rd_ack_offset", cyc - c0, 5);
    chk("rd_strobe_cycles", both, 3);
    chk("rd_rdata", rdata, 32'hCAFEF00D);
    chk("rd_ack_size", ack_size, 2'b11);
    chk("rd_err", err, 0);
    dsack_n = 2'b11;
    wait_for(1, "rd_idle");
    @(negedge clk);

    // Write with a late 16-bit DSACK.
    issue(0, 32'h00DD0044, 2'b10, 32'h12345678);
    wait_for(2, "wr_as_fall");
    chk("wr_as_offset", cyc - c0, 1);
    chk("wr_ds_high_with_as", ds_n, 1);
    @(negedge clk);
    chk("wr_ds_fall", ds_n, 0);
    chk("wr_data_oe", data_oe, 1);
    repeat (2) @(negedge clk);
    dsack_n = 2'b10;
    wait_for(0, "wr_ack");
    chk("wr_ack_offset", cyc - c0, 9);
    chk("wr_ack_size", ack_size, 2'b01);
    chk("wr_data_out", data_out, 32'h12345678);
    chk("wr_rdata_kept", rdata, 32'hCAFEF00D);
    dsack_n = 2'b11;
    wait_for(1, "wr_idle");
    @(negedge clk);

    // Bus error together with DSACK during a read.
    din = 32'hDEADBEEF;
    issue(1, 32'h00DD0048, 2'b01, 0);
    wait_for(2, "be_as_fall");
    berr_n = 0; dsack_n = 2'b00;
    wait_for(0, "be_ack");
    chk("be_err", err, 1);
    chk("be_tout", tout, 0);
    chk("be_rdata_kept", rdata, 32'hCAFEF00D);
    chk("be_ack_size", ack_size, 2'b11);
    repeat (5) @(negedge clk);
    chk("be_hold_busy", busy, 1);
    berr_n = 1;
    repeat (5) @(negedge clk);
    chk("be_hold_busy_dsack", busy, 1);
    dsack_n = 2'b11;
    wait_for(1, "be_idle");
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    // No DSACK: TIMEOUT WAIT cycles, END, then ACK.
    issue(1, 32'h00DD004C, 2'b00, 0);
    wait_for(0, "to_ack");
    chk("to_ack_offset", cyc - c0, 2 + TO + 1);
    chk("to_err", err, 1);
    chk("to_tout", tout, 1);
    wait_for(1, "to_idle");
    @(negedge clk);
`endif

    // Reset in the middle of WAIT.
    issue(1, 32'h00DD0050, 2'b00, 0);
`ifndef BUS_TIMEOUT_EN
    repeat (1000) @(negedge clk);
    chk("nto_busy_hold", busy, 1);
`endif
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_as_n", as_n, 1); chk("mid_rst_ds_n", ds_n, 1);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", addr, 0); chk("mid_rst_ack", ack, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Back-to-back: REQ held high across a completed cycle.
    din = 32'h11112222; dsack_n = 2'b00;
    req = 1; req_rw = 1; req_addr = 32'h00DD0060; req_siz = 2'b00;
    wait_for(0, "b2b_ack1");
    dsack_n = 2'b11;
    wait_for(1, "b2b_idle");
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_idle_cycles", n, 1);
    din = 32'h33334444; dsack_n = 2'b00;
    wait_for(0, "b2b_ack2");
    chk("b2b_rdata2", rdata, 32'h33334444);
    req = 0; dsack_n = 2'b11;
    wait_for(1, "b2b_final_idle");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
